// File: rtl/counter_pkg.sv
// Shared opcodes, FSM encoding and default width
// for the counter command sequencer.
package counter_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_INC   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers
// and a synchronous active-low flush.
module cmd_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [AW:0]  w_diff;
  logic         w_we;
  logic         w_re;

  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty = (r_wr == r_rd);
  assign w_diff  = r_wr - r_rd;
  assign o_level = LW'(w_diff);
  assign o_rdata = r_mem[r_rd[AW-1:0]];
  assign w_we    = i_push && !o_full;
  assign w_re    = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_we && reset)
      r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_we) r_wr <= r_wr + 1'b1;
      if (w_re) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// Buffers counter commands and replays them as
// registered single-cycle pulses, one per two cycles.
module counter_cmd_seq
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             pause,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_load,
  output logic             cnt_inc,
  output logic             cnt_reset,
  output logic             cnt_enable,
  output logic             busy,
  output logic [LW-1:0]    fifo_level
);

  state_t             r_state;
  state_t             w_next;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [WIDTH+1:0]   w_head;
  logic [1:0]         w_op;
  logic [WIDTH-1:0]   w_data;
  logic [WIDTH-1:0]   r_cnt_in;
  logic               r_load;
  logic               r_inc;
  logic               r_clr;
  logic               r_en;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_op      = w_head[WIDTH+1:WIDTH];
  assign w_data    = w_head[WIDTH-1:0];

  cmd_fifo #(
    .W     (WIDTH+2),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({cmd_op, cmd_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_comb begin
    w_next = ST_IDLE;
    w_pop  = 1'b0;
    unique case (r_state)
      ST_ISSUE: w_next = ST_SETTLE;
      ST_IDLE, ST_SETTLE: begin
        if (!w_empty && !pause) begin
          w_pop  = 1'b1;
          w_next = ST_ISSUE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Pulses are launched on the pop edge so they span exactly the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt_in <= '0;
      r_load   <= 1'b0;
      r_inc    <= 1'b0;
      r_clr    <= 1'b1;
      r_en     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_load  <= w_pop && (w_op == CMD_LOAD);
      r_inc   <= w_pop && (w_op == CMD_INC);
      r_clr   <= w_pop && (w_op == CMD_CLEAR);
      r_en    <= !pause;
      if (w_pop && (w_op == CMD_LOAD))
        r_cnt_in <= w_data;
    end
  end

  assign cnt_in     = r_cnt_in;
  assign cnt_load   = r_load;
  assign cnt_inc    = r_inc;
  assign cnt_reset  = r_clr;
  assign cnt_enable = r_en;
  assign busy       = !w_empty || (r_state != ST_IDLE);

endmodule
